// File: rtl/imem_loader.sv
// imem_loader: write side of the instruction memory.
// Assembles a little-endian byte stream into 32-bit words and issues one
// memory write per word at consecutive addresses, holding the CPU meanwhile.
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              r,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              wrap_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [1:0]          byte_cnt_reg;
  logic [ADDR_W-1:0]   remaining_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  // Holds bytes 0..2 of the word in progress; byte 0 ends up in the low lane.
  logic [DATA_W-9:0]   shift_reg;
  logic                mem_wr_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                wrap_err_reg;
  logic                accept;

  assign in_ready = (state_reg == RECV);
  assign cpu_hold = (state_reg == RECV) || (state_reg == WRITE);
  assign accept   = in_ready && in_valid;

  assign mem_wr   = mem_wr_reg;
  assign mem_addr = addr_reg;
  assign mem_data = data_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign wrap_err = wrap_err_reg;

  // Next-state decode for the load sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept && (byte_cnt_reg == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (remaining_reg == ADDR_W'(1)) ? DONE : RECV;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; strobes are registered from the next state.
  always_ff @(posedge clock) begin
    if (!r) begin
      state_reg     <= IDLE;
      byte_cnt_reg  <= '0;
      remaining_reg <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      shift_reg     <= '0;
      mem_wr_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wrap_err_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mem_wr_reg <= (state_next == WRITE);
      done_reg   <= (state_next == DONE);
      busy_reg   <= (state_next == RECV) || (state_next == WRITE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= base_addr;
            remaining_reg <= word_count;
            wrap_err_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
          end
        end
        RECV: begin
          if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= {in_data, shift_reg[DATA_W-9:8]};
            // The output word only changes when a complete word is ready.
            if (byte_cnt_reg == 2'd3) begin
              data_reg <= {in_data, shift_reg};
            end
          end
        end
        WRITE: begin
          addr_reg      <= addr_reg + ADDR_W'(1);
          remaining_reg <= remaining_reg - ADDR_W'(1);
          byte_cnt_reg  <= '0;
          if (addr_reg == '1) begin
            wrap_err_reg <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a small memory and pc model.
module tb_imem_loader;

  logic        clock;
  logic        r;
  logic        start;
  logic [8:0]  base_addr;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        wrap_err;

  int errors = 0;
  int checks = 0;

  logic [8:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] tb_mem [512];
  logic [8:0]  pc;

  imem_loader #(.ADDR_W(9), .DATA_W(32)) dut (
    .clock      (clock),
    .r          (r),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .wrap_err   (wrap_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory write port and write log, one line per write.
  always @(posedge clock) begin
    if (mem_wr === 1'b1) begin
      tb_mem[mem_addr] <= mem_data;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_data);
      $display("write addr=0x%03h data=0x%08h", mem_addr, mem_data);
    end
  end

  // pc held in reset by cpu_hold as the top level does.
  always @(posedge clock) begin
    if (!r || cpu_hold) pc <= '0;
    else                pc <= pc + 9'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [8:0] base, input logic [8:0] cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  logic [31:0] exp_w [4];
  logic [7:0]  b;
  int          base_cnt;

  initial begin
    r = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;

    // Power-on reset
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    r = 1'b1;
    tick();

    // Reset mid-RECV after two bytes
    do_start(9'h005, 9'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("midrst_busy_before", busy, 1);
    base_cnt = wr_addr_q.size();
    r = 1'b0;
    tick(); tick();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_mem_wr", mem_wr, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_data", mem_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_hold", cpu_hold, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wrap_err", wrap_err, 0);
    r = 1'b1;
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    chk("midrst_no_write", 32'(wr_addr_q.size()), 32'(base_cnt));
    chk("midrst_idle_busy", busy, 0);

    // Single word, back-to-back bytes
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(9'h010, 9'd1);
    chk("single_busy", busy, 1);
    chk("single_in_ready", in_ready, 1);
    load_word(32'h00100513);
    chk("single_mem_wr", mem_wr, 1);
    chk("single_mem_addr", mem_addr, 32'h010);
    chk("single_mem_data", mem_data, 32'h00100513);
    chk("single_in_ready_wr", in_ready, 0);
    tick();
    chk("single_done", done, 1);
    chk("single_busy_fall", busy, 0);
    chk("single_wr_low", mem_wr, 0);
    tick();
    chk("single_done_once", done, 0);
    chk("single_wr_count", 32'(wr_addr_q.size()), 1);

    // Three words with in_valid gaps and random bytes
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(9'h000, 9'd3);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom_range(0, 255));
        exp_w[w][8*k +: 8] = b;
        in_valid = 1'b0;
        tick();
        chk("stall_busy", busy, 1);
        send_byte(b);
      end
    end
    tick();
    chk("multi_done", done, 1);
    chk("multi_wr_count", 32'(wr_addr_q.size()), 3);
    for (int w = 0; w < 3; w++) begin
      if (wr_addr_q.size() > w) begin
        chk("multi_addr", wr_addr_q[w], 32'(w));
        chk("multi_data", wr_data_q[w], exp_w[w]);
      end
    end
    tick();

    // Address wrap 0x1FF -> 0x000
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(9'h1FF, 9'd2);
    load_word(32'h11223344);
    load_word(32'h55667788);
    tick();
    chk("wrap_done", done, 1);
    chk("wrap_err_set", wrap_err, 1);
    chk("wrap_wr_count", 32'(wr_addr_q.size()), 2);
    if (wr_addr_q.size() == 2) begin
      chk("wrap_addr0", wr_addr_q[0], 32'h1FF);
      chk("wrap_addr1", wr_addr_q[1], 32'h000);
      chk("wrap_data1", wr_data_q[1], 32'h55667788);
    end
    tick();
    chk("wrap_err_sticky", wrap_err, 1);

    // Zero-count start clears wrap_err and finishes next cycle
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(9'h020, 9'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_wrap_clr", wrap_err, 0);
    tick();
    chk("zero_done_once", done, 0);
    chk("zero_no_write", 32'(wr_addr_q.size()), 0);

    // start during RECV is ignored
    wr_addr_q.delete(); wr_data_q.delete();
    do_start(9'h040, 9'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    start = 1'b1; base_addr = 9'h100; word_count = 9'd5;
    send_byte(8'h03);
    start = 1'b0;
    send_byte(8'h04);
    load_word(32'hCAFEF00D);
    tick();
    chk("ign_done", done, 1);
    chk("ign_wr_count", 32'(wr_addr_q.size()), 2);
    if (wr_addr_q.size() == 2) begin
      chk("ign_addr0", wr_addr_q[0], 32'h040);
      chk("ign_data0", wr_data_q[0], 32'h04030201);
      chk("ign_addr1", wr_addr_q[1], 32'h041);
      chk("ign_data1", wr_data_q[1], 32'hCAFEF00D);
    end
    tick();

    // CPU hold integration: pc stays 0 until done, memory holds the program
    exp_w[0] = 32'h00500093;
    exp_w[1] = 32'h00108113;
    exp_w[2] = 32'h002081B3;
    exp_w[3] = 32'h0000006F;
    do_start(9'h000, 9'd4);
    chk("hold_active", cpu_hold, 1);
    for (int i = 0; i < 4; i++) begin
      load_word(exp_w[i]);
      chk("hold_pc_zero", pc, 0);
    end
    tick();
    chk("hold_done", done, 1);
    chk("hold_pc_at_done", pc, 0);
    tick();
    chk("hold_pc_run1", pc, 1);
    tick();
    chk("hold_pc_run2", pc, 2);
    for (int i = 0; i < 4; i++) chk("hold_imem", tb_mem[i], exp_w[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
